// File: rtl/mac_port_lookup.sv
// MAC-table port lookup: ingress beats are buffered in a first-word-fallthrough FIFO.
// The header beat has its TUSER destination-port field rewritten from the MAC table.
//   state   | meaning
//   IDLE    | wait for a header at the FIFO head, register the table match
//   LOOKUP  | form the new DST field and bump hit/miss counter
//   HDR     | present the rewritten header, pop on TREADY
//   PAYLOAD | pass remaining beats through until TLAST is popped
module mac_port_lookup #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24,
  parameter int NUM_ENTRIES          = 8,
  parameter int FIFO_DEPTH_BITS      = 2
) (
  input  logic                                 AXI_ACLK,
  input  logic                                 AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      S_AXIS_TUSER,
  input  logic                                 S_AXIS_TVALID,
  input  logic                                 S_AXIS_TLAST,
  output logic                                 S_AXIS_TREADY,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]       M_AXIS_TDATA,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     M_AXIS_TSTRB,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      M_AXIS_TUSER,
  output logic                                 M_AXIS_TVALID,
  output logic                                 M_AXIS_TLAST,
  input  logic                                 M_AXIS_TREADY,
  input  logic                                 tbl_wr_en,
  input  logic [$clog2(NUM_ENTRIES)-1:0]       tbl_wr_addr,
  input  logic [47:0]                          tbl_wr_mac,
  input  logic [7:0]                           tbl_wr_port,
  input  logic                                 tbl_wr_valid,
  output logic [31:0]                          hit_count,
  output logic [31:0]                          miss_count
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int SW    = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW    = C_S_AXIS_TUSER_WIDTH;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int FW    = DW + SW + UW + 1;
  localparam logic [FIFO_DEPTH_BITS:0] NF_LEVEL = (FIFO_DEPTH_BITS + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_HDR, S_PAYLOAD} state_t;

  state_t state, state_nxt;
  logic   pop;

  logic [FW-1:0]              fifo_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   count;
  logic                       empty, nearly_full, fifo_wr, fifo_rd, in_ready;
  logic [DW-1:0]              head_data;
  logic [SW-1:0]              head_strb;
  logic [UW-1:0]              head_user;
  logic                       head_last;

  logic [47:0]            tbl_mac  [NUM_ENTRIES];
  logic [7:0]             tbl_port [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] tbl_valid;
  logic                   tbl_hit;
  logic [7:0]             tbl_port_hit;

  logic [47:0] hdr_mac;
  logic [7:0]  hdr_src, dst_new, dst_r, port_r;
  logic        hdr_bcast, hit_r, bcast_r;

  assign empty         = (count == '0);
  assign nearly_full   = (count >= NF_LEVEL);
  assign S_AXIS_TREADY = in_ready & ~nearly_full;
  assign fifo_wr       = S_AXIS_TVALID & S_AXIS_TREADY;
  assign fifo_rd       = pop & ~empty;

  assign {head_last, head_user, head_strb, head_data} = fifo_mem[rd_ptr];

  always_ff @(posedge AXI_ACLK) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
  end

  // in_ready keeps TREADY low while reset is asserted
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (tbl_wr_en) begin
      tbl_mac[tbl_wr_addr]  <= tbl_wr_mac;
      tbl_port[tbl_wr_addr] <= tbl_wr_port;
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) tbl_valid <= '0;
    else if (tbl_wr_en) tbl_valid[tbl_wr_addr] <= tbl_wr_valid;
  end

  assign hdr_mac   = head_data[47:0];
  assign hdr_src   = head_user[SRC_PORT_POS +: 8];
  assign hdr_bcast = (hdr_mac == 48'hFFFF_FFFF_FFFF);

  // scan downward so the lowest matching index wins
  always_comb begin
    tbl_hit      = 1'b0;
    tbl_port_hit = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (tbl_valid[i] && (tbl_mac[i] == hdr_mac)) begin
        tbl_hit      = 1'b1;
        tbl_port_hit = tbl_port[i];
      end
    end
  end

  always_comb begin
    dst_new = (hdr_src & 8'h55) << 1;
    if (bcast_r)    dst_new = 8'h55 & ~hdr_src;
    else if (hit_r) dst_new = port_r;
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    M_AXIS_TVALID = 1'b0;
    case (state)
      S_IDLE:   if (!empty) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = S_HDR;
      S_HDR: begin
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) begin
          pop       = 1'b1;
          state_nxt = head_last ? S_IDLE : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        M_AXIS_TVALID = ~empty;
        if (!empty && M_AXIS_TREADY) begin
          pop = 1'b1;
          if (head_last) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // match result is captured in IDLE so a later table write cannot alter it
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      hit_r      <= 1'b0;
      bcast_r    <= 1'b0;
      port_r     <= '0;
      dst_r      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == S_IDLE && !empty) begin
        hit_r   <= tbl_hit;
        port_r  <= tbl_port_hit;
        bcast_r <= hdr_bcast;
      end
      if (state == S_LOOKUP) begin
        dst_r <= dst_new;
        if (hit_r || bcast_r) hit_count  <= hit_count + 1'b1;
        else                  miss_count <= miss_count + 1'b1;
      end
    end
  end

  always_comb begin
    M_AXIS_TUSER = head_user;
    if (state == S_HDR) M_AXIS_TUSER[DST_PORT_POS +: 8] = dst_r;
  end

  assign M_AXIS_TDATA = head_data;
  assign M_AXIS_TSTRB = head_strb;
  assign M_AXIS_TLAST = head_last;

endmodule
